// File: rtl/cpu_bus_pkg.sv
// Shared encodings and widths for the data-memory bus and its arbiter.
package cpu_bus_pkg;

  localparam int unsigned DMEM_ADDR_W = 9;
  localparam int unsigned DATA_W      = 32;

  // Arbiter ownership state.
  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_e;

  // Which master drives the memory port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_DMA  = 2'd2
  } port_sel_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reports when it sits at LIMIT.
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_VAL)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_VAL);

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA master.
// CPU has priority unless the DMA master is starved or owns a burst.
module dmem_bus_arbiter #(
  parameter int unsigned ADDR_W       = cpu_bus_pkg::DMEM_ADDR_W,
  parameter int unsigned DATA_W       = cpu_bus_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic              i_dma_last,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_rvalid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  import cpu_bus_pkg::*;

  arb_state_e state_q, state_d;
  port_sel_e  sel;
  logic       cpu_win, dma_win;
  logic       starve_at_limit, beat_at_limit;

  // Grant decision; both winners are forced low while reset is asserted.
  always_comb begin
    dma_win = 1'b0;
    if (reset) begin
      unique case (state_q)
        ARB_CPU: dma_win = i_dma_req && (!i_cpu_req || starve_at_limit);
        ARB_DMA: dma_win = i_dma_req;
        default: dma_win = 1'b0;
      endcase
    end
    cpu_win = reset && i_cpu_req && !dma_win;
  end

  // Ownership transitions: enter a burst on a non-final D beat, leave on last/forced/idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_CPU: begin
        if (dma_win && !i_dma_last && (MAX_BURST > 1)) state_d = ARB_DMA;
      end
      ARB_DMA: begin
        if (!i_dma_req || (dma_win && (i_dma_last || beat_at_limit))) state_d = ARB_CPU;
      end
      default: state_d = ARB_CPU;
    endcase
  end

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // Consecutive cycles D waited while C was served.
  sat_counter #(
    .WIDTH (4),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (i_dma_req && cpu_win),
    .clr      (dma_win),
    .at_limit (starve_at_limit)
  );

  // Beats granted in the current ownership; limit marks the forced-exit beat.
  sat_counter #(
    .WIDTH (8),
    .LIMIT (MAX_BURST - 1)
  ) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (dma_win),
    .clr      (state_d == ARB_CPU),
    .at_limit (beat_at_limit)
  );

  // Encode the winning port for the memory mux.
  always_comb begin
    if (dma_win) begin
      sel = SEL_DMA;
    end else if (cpu_win) begin
      sel = SEL_CPU;
    end else begin
      sel = SEL_NONE;
    end
  end

  // Memory port mux; idle port drives zeros.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_write = 1'b0;
    o_mem_read  = 1'b0;
    unique case (sel)
      SEL_CPU: begin
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_write = i_cpu_we;
        o_mem_read  = !i_cpu_we;
      end
      SEL_DMA: begin
        o_mem_addr  = i_dma_addr;
        o_mem_wdata = i_dma_wdata;
        o_mem_write = i_dma_we;
        o_mem_read  = !i_dma_we;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdata = i_mem_rdata;
  assign o_cpu_stall = reset && i_cpu_req && !cpu_win;
  assign o_dma_gnt   = dma_win;

  // DMA read data is captured on the edge after its grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_dma_rdata  <= '0;
      o_dma_rvalid <= 1'b0;
    end else begin
      o_dma_rvalid <= dma_win && !i_dma_we;
      if (dma_win && !i_dma_we) o_dma_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Randomized scoreboard bench for dmem_bus_arbiter with a transaction-level reference model.
module tb_dmem_bus_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned MB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_cpu_req, i_cpu_we, i_dma_req, i_dma_we, i_dma_last;
  logic [AW-1:0] i_cpu_addr, i_dma_addr;
  logic [DW-1:0] i_cpu_wdata, i_dma_wdata, i_mem_rdata;
  logic [DW-1:0] o_cpu_rdata, o_dma_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic          o_cpu_stall, o_dma_gnt, o_dma_rvalid, o_mem_write, o_mem_read;

  dmem_bus_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL),
    .MAX_BURST    (MB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_we     (i_cpu_we),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_wdata  (i_cpu_wdata),
    .o_cpu_rdata  (o_cpu_rdata),
    .o_cpu_stall  (o_cpu_stall),
    .i_dma_req    (i_dma_req),
    .i_dma_we     (i_dma_we),
    .i_dma_last   (i_dma_last),
    .i_dma_addr   (i_dma_addr),
    .i_dma_wdata  (i_dma_wdata),
    .o_dma_gnt    (o_dma_gnt),
    .o_dma_rdata  (o_dma_rdata),
    .o_dma_rvalid (o_dma_rvalid),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_write  (o_mem_write),
    .o_mem_read   (o_mem_read),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT.
  logic [DW-1:0] tb_mem [512];
  assign i_mem_rdata = tb_mem[o_mem_addr];
  always @(posedge clk) if (o_mem_write) tb_mem[o_mem_addr] <= o_mem_wdata;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          stall, gnt, mwr, mrd, chk_crd;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata, crd;
  } exp_t;
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: bus ownership, beats in this ownership, cycles D was denied.
  bit            m_owner;
  int            m_beats, m_denied;
  logic [DW-1:0] ref_mem [512];

  // Stimulus state for C and the D burst master.
  logic          c_req, c_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_data;
  logic          d_we;
  int            d_len;
  bit            d_up;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive pins, predict this cycle's response, advance model and D master.
  task automatic apply();
    exp_t e;
    bit   dw, cw;
    i_cpu_req   = c_req;  i_cpu_we   = c_we;   i_cpu_addr = c_addr; i_cpu_wdata = c_wdata;
    i_dma_req   = d_up;   i_dma_we   = d_we;   i_dma_addr = d_addr; i_dma_wdata = d_data;
    i_dma_last  = (d_len == 1);
    dw = d_up && (m_owner || !c_req || m_denied == int'(SL));
    cw = c_req && !dw;
    e.gnt     = dw;
    e.stall   = c_req && !cw;
    e.mwr     = dw ? d_we : (cw ? c_we : 1'b0);
    e.mrd     = dw ? !d_we : (cw ? !c_we : 1'b0);
    e.maddr   = dw ? d_addr : (cw ? c_addr : '0);
    e.mwdata  = dw ? d_data : c_wdata;
    e.chk_crd = cw && !c_we;
    e.crd     = ref_mem[c_addr];
    exp_q.push_back(e);
    if (dw && !d_we) rd_q.push_back('{due: cyc + 1, data: ref_mem[d_addr]});
    if (dw && d_we) ref_mem[d_addr] = d_data;
    else if (cw && c_we) ref_mem[c_addr] = c_wdata;
    if (dw) begin
      m_denied = 0;
      m_beats++;
      if (d_len == 1 || m_beats == int'(MB)) begin
        m_owner = 0;
        m_beats = 0;
      end else begin
        m_owner = 1;
      end
      d_len--;
      d_addr++;
      d_data = $urandom;
      d_up   = 0;
    end else begin
      if (d_up && cw && m_denied < int'(SL)) m_denied++;
      m_owner = 0;
      m_beats = 0;
    end
  endtask

  task automatic directed_cycle(input logic cr, input logic cwe, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd);
    c_req = cr; c_we = cwe; c_addr = ca; c_wdata = cd;
    if (d_len > 0) d_up = 1;
    @(posedge clk); #1;
    apply();
  endtask

  task automatic random_cycle(input int p_c, input int p_d);
    if (d_len == 0 && $urandom_range(99) < p_d) begin
      d_len  = $urandom_range(1, 12);
      d_addr = AW'($urandom_range(0, 15));
      d_we   = 1'($urandom_range(0, 1));
      d_data = $urandom;
    end
    if (!d_up) d_up = (d_len > 0) && ($urandom_range(99) >= 20);
    c_req   = ($urandom_range(99) < p_c);
    c_we    = 1'($urandom_range(0, 1));
    c_addr  = AW'($urandom_range(0, 15));
    c_wdata = $urandom;
    @(posedge clk); #1;
    apply();
  endtask

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_denied = 0;
    d_len = 0; d_up = 0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_we = 0; d_addr = '0; d_data = '0;
  endtask

  // Monitor: pop one expectation per driven cycle; pop read data on each rvalid.
  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", 32'(o_dma_gnt), 32'(e.gnt));
      chk("stall", 32'(o_cpu_stall), 32'(e.stall));
      chk("mem_write", 32'(o_mem_write), 32'(e.mwr));
      chk("mem_read", 32'(o_mem_read), 32'(e.mrd));
      chk("mem_addr", 32'(o_mem_addr), 32'(e.maddr));
      if (e.mwr) chk("mem_wdata", o_mem_wdata, e.mwdata);
      if (e.chk_crd) chk("cpu_rdata", o_cpu_rdata, e.crd);
    end
    if (o_dma_rvalid) begin
      if (rd_q.size() == 0) begin
        chk("rvalid_spurious", 32'(o_dma_rvalid), 32'd0);
      end else begin
        r = rd_q.pop_front();
        chk("rvalid_cycle", cyc, r.due);
        chk("dma_rdata", o_dma_rdata, r.data);
      end
    end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      r = rd_q.pop_front();
      chk("rvalid_missing", 32'(o_dma_rvalid), 32'd1);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    // Reset forces grants, stall and memory enables low even with both requesting.
    reset = 1'b0;
    i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = '0; i_cpu_wdata = '0;
    i_dma_req = 1; i_dma_we = 1; i_dma_last = 0; i_dma_addr = '0; i_dma_wdata = '0;
    #12;
    chk("rst_gnt", 32'(o_dma_gnt), 0);
    chk("rst_stall", 32'(o_cpu_stall), 0);
    chk("rst_mem_write", 32'(o_mem_write), 0);
    chk("rst_mem_read", 32'(o_mem_read), 0);
    chk("rst_rvalid", 32'(o_dma_rvalid), 0);
    chk("rst_rdata", o_dma_rdata, 0);
    i_cpu_req = 0; i_dma_req = 0;
    @(posedge clk); #3 reset = 1'b1;

    // C-only write then read-back in the same cycle, never stalled.
    directed_cycle(1, 1, 9'd5, 32'hDEADBEEF);
    directed_cycle(1, 0, 9'd5, '0);
    #1;
    chk("t1_rdata", o_cpu_rdata, 32'hDEADBEEF);
    chk("t1_stall", 32'(o_cpu_stall), 0);

    // Starvation guard: D gets the bus on the fifth contested cycle.
    d_len = 1; d_addr = 9'd7; d_we = 0; d_data = '0;
    for (int i = 0; i < 5; i++) begin
      directed_cycle(1, 0, 9'd3, '0);
      #1;
      chk("t2_gnt", 32'(o_dma_gnt), 32'(i == 4));
      chk("t2_stall", 32'(o_cpu_stall), 32'(i == 4));
    end
    directed_cycle(0, 0, '0, '0);

    // Three-beat write burst; C arriving in beat 2 waits exactly two cycles.
    d_len = 3; d_addr = 9'd0; d_we = 1; d_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      directed_cycle(i > 0, 0, 9'd1, '0);
      #1;
      chk("t3_gnt", 32'(o_dma_gnt), 32'(i < 3));
      chk("t3_stall", 32'(o_cpu_stall), 32'(i == 1 || i == 2));
    end

    // Four-beat read-back of the burst region.
    d_len = 4; d_addr = 9'd0; d_we = 0;
    for (int i = 0; i < 6; i++) directed_cycle(0, 0, '0, '0);

    // Twelve-beat burst against constant C traffic: forced exit after MAX_BURST beats.
    d_len = 12; d_addr = 9'd32; d_we = 1; d_data = $urandom;
    for (int i = 0; i < 80 && d_len > 0; i++) directed_cycle(1, 0, 9'(i % 16), '0);
    if (d_len > 0) chk("t4_timeout", 32'(d_len), 0);

    // Randomized traffic at several C loads.
    for (int i = 0; i < 500; i++) random_cycle(20, 40);
    for (int i = 0; i < 500; i++) random_cycle(60, 50);
    for (int i = 0; i < 500; i++) random_cycle(95, 60);

    // Reset in beat 2 of a burst: grant and write must drop at once.
    d_len = 0; d_up = 0;
    for (int i = 0; i < 3; i++) directed_cycle(0, 0, '0, '0);
    d_len = 4; d_addr = 9'd40; d_we = 1; d_data = $urandom;
    directed_cycle(0, 0, '0, '0);
    @(posedge clk); #1;
    i_dma_req = 1; i_dma_we = 1; i_dma_last = 0; i_dma_addr = 9'd41; i_cpu_req = 1;
    #1 reset = 1'b0;
    #1;
    chk("t6_gnt", 32'(o_dma_gnt), 0);
    chk("t6_mem_write", 32'(o_mem_write), 0);
    chk("t6_mem_read", 32'(o_mem_read), 0);
    chk("t6_stall", 32'(o_cpu_stall), 0);
    i_dma_req = 0; i_cpu_req = 0;
    model_reset();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6_rvalid", 32'(o_dma_rvalid), 0);
    chk("t6_rdata", o_dma_rdata, 0);
    // Fresh start: ARB_CPU with counters at zero, so D waits four contested cycles.
    d_len = 1; d_addr = 9'd41; d_we = 0;
    for (int i = 0; i < 5; i++) directed_cycle(1, 0, 9'd2, '0);
    for (int i = 0; i < 300; i++) random_cycle(70, 50);

    d_len = 0; d_up = 0;
    for (int i = 0; i < 3; i++) directed_cycle(0, 0, '0, '0);
    repeat (2) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
